outfifo_axis: RTL and testbench
===============================

OUTFIFO_AXIS -- requirements
Module: outfifo_axis

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, result word width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of 2, >=2).
REQ-003 SHALL have parameter PKT_LEN, default 8, beats per AXI-Stream packet (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port outfifo_write  input  1  push request from control unit.
REQ-007 SHALL have port outfifo_din  input  DATA_WIDTH  result word from MXU.
REQ-008 SHALL have port outfifo_is_full  output  1  no free entry.
REQ-009 SHALL have port outfifo_flush  input  1  synchronous clear.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH  head word.
REQ-011 SHALL have port m_axis_tvalid  output  1  head word valid.
REQ-012 SHALL have port m_axis_tready  input  1  downstream accepts.
REQ-013 SHALL have port m_axis_tlast  output  1  last beat of packet.
REQ-014 SHALL have port outfifo_count  output  $clog2(DEPTH)+1  occupancy.
REQ-015 SHALL have port outfifo_overflow  output  1  sticky dropped-write flag.

Function
REQ-016 Push SHALL occur when outfifo_write=1 and outfifo_is_full=0 at a clock edge; word stored at write pointer, pointer +1 mod DEPTH.
REQ-017 Pop SHALL occur when m_axis_tvalid=1 and m_axis_tready=1; read pointer +1 mod DEPTH.
REQ-018 outfifo_is_full SHALL equal (count==DEPTH); m_axis_tvalid SHALL equal (count!=0); both registered-state derived, no combinational path from inputs.
REQ-019 Write-to-tvalid latency SHALL be one cycle: word pushed at edge N drives m_axis_tdata/tvalid after edge N.
REQ-020 Push and pop in the same cycle with 0<count<DEPTH SHALL leave count unchanged.
REQ-021 Push while full SHALL be dropped even if a pop occurs that cycle, and SHALL set outfifo_overflow.
REQ-022 Push while empty SHALL not pop that cycle (tvalid was 0).
REQ-023 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable.
REQ-024 A beat counter (0..PKT_LEN-1) SHALL increment on each pop and wrap to 0 after the pop with tlast=1.
REQ-025 m_axis_tlast SHALL be 1 iff tvalid=1 and beat counter==PKT_LEN-1; PKT_LEN=1 gives tlast on every beat.
REQ-026 outfifo_flush=1 SHALL, at the edge, zero pointers, count, beat counter and overflow, taking priority over simultaneous push/pop.
REQ-027 Pointers SHALL wrap silently; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-028 reset=1 SHALL asynchronously clear pointers, count, beat counter and overflow.
REQ-029 During/after reset: outfifo_is_full=0, m_axis_tvalid=0, m_axis_tlast=0, outfifo_count=0, outfifo_overflow=0; m_axis_tdata don't-care.
REQ-030 Reset mid-packet SHALL discard stored data and restart beat counting at 0.
REQ-031 Storage array SHALL not be reset (RAM inference).

Structure
REQ-032 Shared package dtpu_pkg SHALL hold default DATA_WIDTH, DEPTH, PKT_LEN constants.
REQ-033 Storage SHALL be a sub-module outfifo_mem: simple dual-port, synchronous write, asynchronous read, no reset.
REQ-034 Pointer, count, flag and beat-counter logic SHALL reside in outfifo_axis.

Verification
REQ-035 Single push 0xA5 with tready=1 -> tvalid=1 next cycle with tdata=0xA5, popped, count back to 0.
REQ-036 16 pushes, tready=0 -> full=1 at count 16; 17th push dropped, overflow=1, count stays 16.
REQ-037 Full FIFO, push 0x55 and tready=1 same cycle -> count 15, 0x55 not stored, overflow=1.
REQ-038 20 words streamed, tready=1 -> tlast=1 on beats 8 and 16 only; beats 17-20 carry tlast=0.
REQ-039 tready toggling 1/0 each cycle -> tdata/tlast hold during tready=0, sequence order preserved.
REQ-040 Push 5 words, assert flush with simultaneous push -> next cycle count=0, tvalid=0; async reset mid-packet -> all outputs zero immediately.

Source files
------------

// File: rtl/dtpu_pkg.sv
// Shared defaults and small helpers for the DTPU datapath blocks.
package dtpu_pkg;

    localparam int OUTFIFO_DATA_WIDTH = 64;
    localparam int OUTFIFO_DEPTH      = 16;
    localparam int OUTFIFO_PKT_LEN    = 8;

    // A single-beat packet still needs a 1-bit counter to keep the vector legal.
    function automatic int beat_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/outfifo_mem.sv
// Result-word storage: simple dual-port, synchronous write, asynchronous read.
// No reset so the array maps onto distributed RAM.
module outfifo_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/outfifo_axis.sv
// Output FIFO between the MXU and an AXI-Stream master port, with packet
// framing (tlast every PKT_LEN beats) and a sticky dropped-write flag.
module outfifo_axis
    import dtpu_pkg::*;
#(
    parameter int DATA_WIDTH = OUTFIFO_DATA_WIDTH,
    parameter int DEPTH      = OUTFIFO_DEPTH,
    parameter int PKT_LEN    = OUTFIFO_PKT_LEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       outfifo_write,
    input  logic [DATA_WIDTH-1:0]      outfifo_din,
    output logic                       outfifo_is_full,
    input  logic                       outfifo_flush,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     outfifo_count,
    output logic                       outfifo_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = beat_width(PKT_LEN);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] beat;
    logic          overflow;
    logic          push, pop;

    // Flags come only from registered state so downstream sees no input-to-output path.
    assign outfifo_is_full  = (count == FULL_CNT);
    assign m_axis_tvalid    = (count != '0);
    assign m_axis_tlast     = m_axis_tvalid && (beat == LAST_BEAT);
    assign outfifo_count    = count;
    assign outfifo_overflow = overflow;

    assign push = outfifo_write && !outfifo_is_full;
    assign pop  = m_axis_tvalid && m_axis_tready;

    outfifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !outfifo_flush),
        .waddr (wr_ptr),
        .wdata (outfifo_din),
        .raddr (rd_ptr),
        .rdata (m_axis_tdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat     <= '0;
            overflow <= 1'b0;
        end else if (outfifo_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                beat   <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A full FIFO drops the write even if a pop frees a slot this cycle.
            if (outfifo_write && outfifo_is_full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_outfifo_axis.sv
// Randomized and directed checks of outfifo_axis against a queue-based model.
module tb_outfifo_axis;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int PKT   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          outfifo_write;
    logic [DW-1:0] outfifo_din;
    logic          outfifo_is_full;
    logic          outfifo_flush;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [4:0]    outfifo_count;
    logic          outfifo_overflow;

    outfifo_axis #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_LEN(PKT)) dut (
        .clk              (clk),
        .reset            (reset),
        .outfifo_write    (outfifo_write),
        .outfifo_din      (outfifo_din),
        .outfifo_is_full  (outfifo_is_full),
        .outfifo_flush    (outfifo_flush),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .outfifo_count    (outfifo_count),
        .outfifo_overflow (outfifo_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queue of stored words, beat index within packet, sticky flag.
    logic [DW-1:0] mq[$];
    int            mbeat;
    bit            movf;

    logic [4:0]    exp_cnt;
    logic          exp_valid, exp_full, exp_last, exp_ovf;
    logic [DW-1:0] exp_data;

    task automatic set_exp();
        exp_cnt   = 5'(mq.size());
        exp_valid = (mq.size() != 0);
        exp_full  = (mq.size() == DEPTH);
        exp_last  = exp_valid && (mbeat == PKT - 1);
        exp_ovf   = movf;
        exp_data  = exp_valid ? mq[0] : '0;
    endtask

    task automatic model_clear();
        mq.delete();
        mbeat = 0;
        movf  = 0;
        set_exp();
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1ns later.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        bit was_full, do_pop;
        outfifo_write = w;
        outfifo_din   = d;
        m_axis_tready = r;
        outfifo_flush = f;
        @(posedge clk);
        if (f) begin
            mq.delete();
            mbeat = 0;
            movf  = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = (mq.size() != 0) && r;
            if (w && was_full) movf = 1;
            if (do_pop) begin
                void'(mq.pop_front());
                mbeat = (mbeat + 1) % PKT;
            end
            if (w && !was_full) mq.push_back(d);
        end
        #1;
        set_exp();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        outfifo_write = 0; outfifo_din = '0; m_axis_tready = 0; outfifo_flush = 0;
        model_clear();
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
        checks++; if (outfifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", outfifo_count); end
        checks++; if (outfifo_is_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", outfifo_is_full); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); end
        checks++; if (outfifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", outfifo_overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        step(1'b1, 64'hA5, 1'b1, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hA5) begin errors++;
            $display("FAIL single_push got v=%b d=%h want v=1 d=a5", m_axis_tvalid, m_axis_tdata); end
        checks++; if (outfifo_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d want=1", outfifo_count); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (outfifo_count !== 5'd0 || m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL single_pop got cnt=%0d v=%b want cnt=0 v=0", outfifo_count, m_axis_tvalid); end
    endtask

    task automatic test_fill_overflow();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 64'h1000 + 64'(i), 1'b0, 1'b0);
            checks++; if (outfifo_count !== exp_cnt || outfifo_is_full !== exp_full) begin errors++;
                $display("FAIL fill_%0d got cnt=%0d full=%b want cnt=%0d full=%b", i, outfifo_count, outfifo_is_full, exp_cnt, exp_full); end
        end
        checks++; if (outfifo_is_full !== 1'b1 || outfifo_count !== 5'd16) begin errors++;
            $display("FAIL full_at_16 got full=%b cnt=%0d want 1/16", outfifo_is_full, outfifo_count); end
        step(1'b1, 64'hDEAD, 1'b0, 1'b0);
        checks++; if (outfifo_overflow !== 1'b1 || outfifo_count !== 5'd16) begin errors++;
            $display("FAIL drop_17th got ovf=%b cnt=%0d want 1/16", outfifo_overflow, outfifo_count); end
        checks++; if (m_axis_tdata !== 64'h1000) begin errors++; $display("FAIL head_kept got=%h want=1000", m_axis_tdata); end
    endtask

    task automatic test_full_push_pop();
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (outfifo_overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b want=0", outfifo_overflow); end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
        step(1'b1, 64'h55, 1'b1, 1'b0);
        checks++; if (outfifo_count !== 5'd15 || outfifo_overflow !== 1'b1) begin errors++;
            $display("FAIL full_push_pop got cnt=%0d ovf=%b want 15/1", outfifo_count, outfifo_overflow); end
        for (int i = 0; i < 15; i++) begin
            checks++; if (m_axis_tdata !== exp_data || m_axis_tdata === 64'h55) begin errors++;
                $display("FAIL drain_%0d got=%h want=%h", i, m_axis_tdata, exp_data); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (outfifo_count !== 5'd0 || m_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL drained got cnt=%0d v=%b want 0/0", outfifo_count, m_axis_tvalid); end
    endtask

    // Streams n words with tready=1 and checks framing by beat index alone.
    task automatic stream_packets(input int n, input string tag);
        int beats = 0, lasts = 0;
        for (int i = 0; i <= n; i++) begin
            step(i < n, 64'($urandom), 1'b1, 1'b0);
            if (m_axis_tvalid === 1'b1) begin
                checks++; if (m_axis_tlast !== ((beats % PKT) == PKT - 1) || m_axis_tdata !== exp_data) begin errors++;
                    $display("FAIL %s_beat%0d got last=%b d=%h want last=%b d=%h", tag, beats + 1,
                             m_axis_tlast, m_axis_tdata, (beats % PKT) == PKT - 1, exp_data); end
                if (m_axis_tlast === 1'b1) lasts++;
                beats++;
            end
        end
        checks++; if (beats != n || lasts != n / PKT) begin errors++;
            $display("FAIL %s_totals got beats=%0d lasts=%0d want %0d/%0d", tag, beats, lasts, n, n / PKT); end
    endtask

    task automatic test_tlast();
        step(1'b0, '0, 1'b0, 1'b1);
        stream_packets(20, "tlast");
    endtask

    task automatic test_ready_toggle();
        logic [DW-1:0] pd;
        logic          pl;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 64'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            step(i % 3 == 0, 64'($urandom), (i % 2) == 0, 1'b0);
            if ((i % 2) == 1 && m_axis_tvalid === 1'b1) begin
                checks++; if (m_axis_tdata !== pd || m_axis_tlast !== pl) begin errors++;
                    $display("FAIL hold_%0d got d=%h l=%b want d=%h l=%b", i, m_axis_tdata, m_axis_tlast, pd, pl); end
            end
            checks++; if (m_axis_tvalid !== exp_valid || (exp_valid && (m_axis_tdata !== exp_data || m_axis_tlast !== exp_last))) begin errors++;
                $display("FAIL toggle_%0d got v=%b d=%h l=%b want v=%b d=%h l=%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                         exp_valid, exp_data, exp_last); end
        end
    endtask

    task automatic test_flush();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 64'(i + 1), 1'b0, 1'b0);
        checks++; if (outfifo_count !== 5'd5) begin errors++; $display("FAIL pre_flush_count got=%0d want=5", outfifo_count); end
        step(1'b1, 64'h77, 1'b1, 1'b1);
        checks++; if (outfifo_count !== 5'd0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin errors++;
            $display("FAIL flush_push got cnt=%0d v=%b l=%b want 0/0/0", outfifo_count, m_axis_tvalid, m_axis_tlast); end
    endtask

    task automatic test_reset_mid_packet();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b1, 64'($urandom), 1'b1, 1'b0);
        step(1'b1, 64'hBEEF, 1'b0, 1'b0);
        step(1'b1, 64'hBEEF, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || outfifo_count !== 5'd0 || m_axis_tlast !== 1'b0 ||
                      outfifo_is_full !== 1'b0 || outfifo_overflow !== 1'b0) begin errors++;
            $display("FAIL async_reset got v=%b cnt=%0d l=%b f=%b o=%b want all 0", m_axis_tvalid, outfifo_count,
                     m_axis_tlast, outfifo_is_full, outfifo_overflow); end
        model_clear();
        outfifo_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        stream_packets(8, "restart");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, {32'($urandom), 32'($urandom)},
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
            checks++; if (outfifo_count !== exp_cnt || outfifo_is_full !== exp_full || m_axis_tvalid !== exp_valid ||
                          m_axis_tlast !== exp_last || outfifo_overflow !== exp_ovf ||
                          (exp_valid && m_axis_tdata !== exp_data)) begin errors++;
                $display("FAIL rand_%0d got cnt=%0d f=%b v=%b l=%b o=%b d=%h want cnt=%0d f=%b v=%b l=%b o=%b d=%h", i,
                         outfifo_count, outfifo_is_full, m_axis_tvalid, m_axis_tlast, outfifo_overflow, m_axis_tdata,
                         exp_cnt, exp_full, exp_valid, exp_last, exp_ovf, exp_data); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_tlast();
        test_ready_toggle();
        test_flush();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
